// File: rtl/me_pkg.sv
// rtl/me_pkg.sv - shared sizes, pixel type and window index helper for the ME frame memory
package me_pkg;
    localparam int PIX_W   = 8;
    localparam int R_DIM   = 16;
    localparam int S_DIM   = 31;
    localparam int R_DEPTH = R_DIM * R_DIM;
    localparam int S_DEPTH = S_DIM * S_DIM;
    localparam int RA_W    = 8;
    localparam int SA_W    = 10;

    typedef logic [PIX_W-1:0] pixel_t;

    function automatic logic [SA_W-1:0] s_index(input logic [4:0] row, input logic [4:0] col);
        return SA_W'(int'(row) * S_DIM + int'(col));
    endfunction
endpackage

// File: rtl/me_mem_bank.sv
// rtl/me_mem_bank.sv - pixel array with sync clear/write and NRD combinational read ports
module me_mem_bank
    import me_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int NRD   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  pixel_t               wdata,
    input  logic [NRD*AW-1:0]    raddr,
    output logic [NRD*PIX_W-1:0] rdata
);
    // One extra bit so DEPTH itself is representable (e.g. 256 with AW=8).
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    pixel_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we && ({1'b0, waddr} < DEPTH_W)) begin
            mem[waddr] <= wdata;
        end
    end

    // Codes past the end of the array read as zero rather than aliasing or going X.
    always_comb begin
        rdata = '0;
        for (int k = 0; k < NRD; k++) begin
            if ({1'b0, raddr[k*AW +: AW]} < DEPTH_W) begin
                rdata[k*PIX_W +: PIX_W] = mem[raddr[k*AW +: AW]];
            end
        end
    end
endmodule

// File: rtl/me_frame_memory.sv
// rtl/me_frame_memory.sv - reference block and search window store for the motion estimator
module me_frame_memory
    import me_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [RA_W-1:0] AddressR,
    input  logic [SA_W-1:0] AddressS1,
    input  logic [SA_W-1:0] AddressS2,
    output pixel_t          R,
    output pixel_t          S1,
    output pixel_t          S2,
    input  logic            load_en,
    input  logic            load_sel,
    input  logic [SA_W-1:0] load_addr,
    input  pixel_t          load_data
);
    logic r_we;
    logic s_we;

    // R writes with upper address bits set are dropped instead of wrapping into the block.
    assign r_we = load_en && !load_sel && (load_addr[SA_W-1:RA_W] == '0);
    assign s_we = load_en && load_sel;

    me_mem_bank #(.DEPTH(R_DEPTH), .AW(RA_W), .NRD(1)) u_r_bank (
        .clk   (clk),
        .reset (reset),
        .we    (r_we),
        .waddr (load_addr[RA_W-1:0]),
        .wdata (load_data),
        .raddr (AddressR),
        .rdata (R)
    );

    me_mem_bank #(.DEPTH(S_DEPTH), .AW(SA_W), .NRD(2)) u_s_bank (
        .clk   (clk),
        .reset (reset),
        .we    (s_we),
        .waddr (load_addr),
        .wdata (load_data),
        .raddr ({AddressS2, AddressS1}),
        .rdata ({S2, S1})
    );
endmodule

// File: tb/tb_me_frame_memory.sv
// tb/tb_me_frame_memory.sv - randomized scoreboard bench for me_frame_memory
module tb_me_frame_memory;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] AddressR = '0;
    logic [9:0] AddressS1 = '0;
    logic [9:0] AddressS2 = '0;
    logic [7:0] R;
    logic [7:0] S1;
    logic [7:0] S2;
    logic       load_en = 1'b0;
    logic       load_sel = 1'b0;
    logic [9:0] load_addr = '0;
    logic [7:0] load_data = '0;

    always #5 clk = ~clk;

    me_frame_memory dut (
        .clk       (clk),
        .reset     (reset),
        .AddressR  (AddressR),
        .AddressS1 (AddressS1),
        .AddressS2 (AddressS2),
        .R         (R),
        .S1        (S1),
        .S2        (S2),
        .load_en   (load_en),
        .load_sel  (load_sel),
        .load_addr (load_addr),
        .load_data (load_data)
    );

    typedef struct {
        string      name;
        logic [7:0] r;
        logic [7:0] s1;
        logic [7:0] s2;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   chk_valid = 1'b0;

    int r_m[256];
    int s_m[961];

    function automatic logic [7:0] m_r(input int a);
        return 8'(r_m[a % 256]);
    endfunction

    function automatic logic [7:0] m_s(input int a);
        return (a < 961) ? 8'(s_m[a]) : 8'h00;
    endfunction

    function automatic void m_clear();
        foreach (r_m[i]) r_m[i] = 0;
        foreach (s_m[i]) s_m[i] = 0;
    endfunction

    task automatic step(input bit rst, input bit le, input bit sel, input int la, input int ld,
                        input int ar, input int a1, input int a2, input bit chk, input string nm);
        exp_t e;
        reset     = rst;
        load_en   = le;
        load_sel  = sel;
        load_addr = la[9:0];
        load_data = ld[7:0];
        AddressR  = ar[7:0];
        AddressS1 = a1[9:0];
        AddressS2 = a2[9:0];
        if (chk) begin
            e.name = nm;
            e.r    = m_r(ar);
            e.s1   = m_s(a1);
            e.s2   = m_s(a2);
            q.push_back(e);
        end
        chk_valid = chk;
        @(posedge clk);
        if (rst) begin
            m_clear();
        end else if (le) begin
            if (sel) begin
                if (la < 961) s_m[la] = ld & 255;
            end else if (la < 256) begin
                r_m[la] = ld & 255;
            end
        end
        #1;
    endtask

    task automatic check_lit(input int ar, input int a1, input int a2,
                             input logic [7:0] er, input logic [7:0] e1, input logic [7:0] e2,
                             input string nm);
        exp_t e;
        reset     = 1'b0;
        load_en   = 1'b0;
        AddressR  = ar[7:0];
        AddressS1 = a1[9:0];
        AddressS2 = a2[9:0];
        e.name = nm;
        e.r    = er;
        e.s1   = e1;
        e.s2   = e2;
        q.push_back(e);
        chk_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_valid) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s: scoreboard empty when a check was due", "queue");
            end else begin
                exp_t e;
                e = q.pop_front();
                n_cmp += 3;
                if (R !== e.r) begin
                    n_bad++;
                    $display("FAIL %s R: got %h expected %h (AddressR=%0d)", e.name, R, e.r, AddressR);
                end
                if (S1 !== e.s1) begin
                    n_bad++;
                    $display("FAIL %s S1: got %h expected %h (AddressS1=%0d)", e.name, S1, e.s1, AddressS1);
                end
                if (S2 !== e.s2) begin
                    n_bad++;
                    $display("FAIL %s S2: got %h expected %h (AddressS2=%0d)", e.name, S2, e.s2, AddressS2);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m_clear();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, "init");

        // Random fill, then a single reset cycle must clear every address.
        for (int i = 0; i < 256; i++) step(0, 1, 0, i, $urandom_range(1, 255), 0, 0, 0, 0, "fill_r");
        for (int i = 0; i < 961; i++) step(0, 1, 1, i, $urandom_range(1, 255), 0, 0, 0, 0, "fill_s");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, "reset");
        for (int i = 0; i < 1024; i++) step(0, 0, 0, 0, 0, i % 256, i, 1023 - i, 1, "reset_clear");

        // Known pattern load.
        for (int i = 0; i < 256; i++) step(0, 1, 0, i, i, 0, 0, 0, 0, "load_r");
        for (int i = 0; i < 961; i++) step(0, 1, 1, i, (i & 255) ^ 8'hA5, 0, 0, 0, 0, "load_s");
        check_lit(8'h37, 960, 0, 8'h37, 8'h65, 8'hA5, "pattern");
        check_lit(0, 32, 960, 8'h00, 8'h85, 8'h65, "dual_a");
        check_lit(255, 33, 960, 8'hFF, 8'h84, 8'h65, "dual_b");
        check_lit(1, 31, 31, 8'h01, 8'hBA, 8'hBA, "dual_equal");

        // Out-of-range S write is dropped and reads past the window return zero.
        step(0, 1, 1, 961, 8'hFF, 0, 0, 0, 0, "oor_write");
        check_lit(0, 961, 1023, 8'h00, 8'h00, 8'h00, "oor_read");
        check_lit(0, 960, 961, 8'h00, 8'h65, 8'h00, "oor_keep");

        // R write with upper address bits set must not alias onto R[5].
        step(0, 1, 0, 10'h105, 8'h99, 5, 0, 0, 0, "r_alias");
        check_lit(5, 0, 0, 8'h05, 8'hA5, 8'hA5, "r_alias_chk");

        // Read-during-write: old value before the edge, new value after.
        step(0, 1, 0, 5, 8'h11, 0, 0, 0, 0, "rdw_prep");
        step(0, 1, 0, 5, 8'h22, 5, 0, 0, 1, "rdw_old");
        check_lit(5, 0, 0, 8'h22, 8'hA5, 8'hA5, "rdw_new");

        // Reset wins over a coincident load.
        step(1, 1, 1, 0, 8'h7E, 0, 0, 0, 0, "rst_vs_load");
        check_lit(5, 0, 960, 8'h00, 8'h00, 8'h00, "rst_vs_load_chk");

        // Random mixed traffic against the reference model.
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 199) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 1023), $urandom_range(0, 255), $urandom_range(0, 255),
                 $urandom_range(0, 1023), $urandom_range(0, 1023), 1, "random");
        end

        chk_valid = 1'b0;
        load_en   = 1'b0;
        @(negedge clk);
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
